// File: rtl/decode_regfile.sv
// decode_regfile -- Y86-64 decode/writeback stage.
//   15x64-bit register file (IDs 0..14, 4'hF = RNONE), two combinational read
//   ports with same-cycle writeback bypass, two write ports (E and M; M wins on
//   a shared destination), and the D->E pipeline register feeding execute.
// Ports:
//   clk_i, rst_n_i             clock (rising edge), async active-low reset
//   icode_i, ifun_i, rA_i,
//   rB_i, valC_i, valP_i       fetched instruction fields
//   stall_i, bubble_i          D->E control (bubble has priority over stall)
//   wE_dst_i/wE_val_i,
//   wM_dst_i/wM_val_i          writeback ports (RNONE = no write)
//   e_*_o                      registered D->E outputs, e_valid_o=0 on bubble
module decode_regfile #(
    parameter int         NREG = 15,
    parameter logic [3:0] RSP  = 4'h4,
    parameter int         W    = 64
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [3:0]   icode_i,
    input  logic [3:0]   ifun_i,
    input  logic [3:0]   rA_i,
    input  logic [3:0]   rB_i,
    input  logic [W-1:0] valC_i,
    input  logic [W-1:0] valP_i,
    input  logic         stall_i,
    input  logic         bubble_i,
    input  logic [3:0]   wE_dst_i,
    input  logic [W-1:0] wE_val_i,
    input  logic [3:0]   wM_dst_i,
    input  logic [W-1:0] wM_val_i,
    output logic [3:0]   e_icode_o,
    output logic [3:0]   e_ifun_o,
    output logic [W-1:0] e_valA_o,
    output logic [W-1:0] e_valB_o,
    output logic [W-1:0] e_valC_o,
    output logic [3:0]   e_dstE_o,
    output logic [3:0]   e_dstM_o,
    output logic         e_valid_o
);
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    logic [W-1:0] regs_q [NREG];

    logic [3:0]   srcA, srcB, dstE, dstM;
    logic [W-1:0] rdA, rdB;

    logic [3:0]   icode_q, icode_d, ifun_q, ifun_d;
    logic [W-1:0] valA_q, valA_d, valB_q, valB_d, valC_q, valC_d;
    logic [3:0]   dstE_q, dstE_d, dstM_q, dstM_d;
    logic         valid_q, valid_d;

    // Register specifier selection; unknown icodes fall to RNONE everywhere.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode_i)
            IRRMOVQ: begin srcA = rA_i; dstE = rB_i; end
            IIRMOVQ: dstE = rB_i;
            IRMMOVQ: begin srcA = rA_i; srcB = rB_i; end
            IMRMOVQ: begin srcB = rB_i; dstM = rA_i; end
            IOPQ:    begin srcA = rA_i; srcB = rB_i; dstE = rB_i; end
            ICALL:   begin srcB = RSP; dstE = RSP; end
            IRET:    begin srcA = RSP; srcB = RSP; dstE = RSP; end
            IPUSHQ:  begin srcA = rA_i; srcB = RSP; dstE = RSP; end
            IPOPQ:   begin srcA = RSP; srcB = RSP; dstE = RSP; dstM = rA_i; end
            default: ;
        endcase
    end

    // Bypass order mirrors the write priority: M beats E, both beat the array.
    always_comb begin
        if (srcA == RNONE)          rdA = '0;
        else if (srcA == wM_dst_i)  rdA = wM_val_i;
        else if (srcA == wE_dst_i)  rdA = wE_val_i;
        else                        rdA = regs_q[srcA];
        if (srcB == RNONE)          rdB = '0;
        else if (srcB == wM_dst_i)  rdB = wM_val_i;
        else if (srcB == wE_dst_i)  rdB = wE_val_i;
        else                        rdB = regs_q[srcB];
    end

    // Write ports ignore stall/bubble; M is assigned last so it wins on a tie.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            if (wE_dst_i != RNONE) regs_q[wE_dst_i] <= wE_val_i;
            if (wM_dst_i != RNONE) regs_q[wM_dst_i] <= wM_val_i;
        end
    end

    // D->E next state: bubble > stall > load.
    always_comb begin
        icode_d = icode_q;
        ifun_d  = ifun_q;
        valA_d  = valA_q;
        valB_d  = valB_q;
        valC_d  = valC_q;
        dstE_d  = dstE_q;
        dstM_d  = dstM_q;
        valid_d = valid_q;
        if (bubble_i) begin
            icode_d = INOP;
            ifun_d  = 4'h0;
            valA_d  = '0;
            valB_d  = '0;
            valC_d  = '0;
            dstE_d  = RNONE;
            dstM_d  = RNONE;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            icode_d = icode_i;
            ifun_d  = ifun_i;
            valA_d  = (icode_i == ICALL || icode_i == IJXX) ? valP_i : rdA;
            valB_d  = rdB;
            valC_d  = valC_i;
            dstE_d  = dstE;
            dstM_d  = dstM;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            icode_q <= INOP;
            ifun_q  <= 4'h0;
            valA_q  <= '0;
            valB_q  <= '0;
            valC_q  <= '0;
            dstE_q  <= RNONE;
            dstM_q  <= RNONE;
            valid_q <= 1'b0;
        end else begin
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            valA_q  <= valA_d;
            valB_q  <= valB_d;
            valC_q  <= valC_d;
            dstE_q  <= dstE_d;
            dstM_q  <= dstM_d;
            valid_q <= valid_d;
        end
    end

    assign e_icode_o = icode_q;
    assign e_ifun_o  = ifun_q;
    assign e_valA_o  = valA_q;
    assign e_valB_o  = valB_q;
    assign e_valC_o  = valC_q;
    assign e_dstE_o  = dstE_q;
    assign e_dstM_o  = dstM_q;
    assign e_valid_o = valid_q;
endmodule

// File: tb/tb_decode_regfile.sv
module tb_decode_regfile;
    logic        clk, rst_n;
    logic [3:0]  icode, ifun, rA, rB, wE_dst, wM_dst;
    logic [63:0] valC, valP, wE_val, wM_val;
    logic        stall, bubble;
    logic [3:0]  e_icode, e_ifun, e_dstE, e_dstM;
    logic [63:0] e_valA, e_valB, e_valC;
    logic        e_valid;
    int          tests = 0, fails = 0;

    decode_regfile dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .icode_i(icode), .ifun_i(ifun), .rA_i(rA), .rB_i(rB),
        .valC_i(valC), .valP_i(valP), .stall_i(stall), .bubble_i(bubble),
        .wE_dst_i(wE_dst), .wE_val_i(wE_val), .wM_dst_i(wM_dst), .wM_val_i(wM_val),
        .e_icode_o(e_icode), .e_ifun_o(e_ifun), .e_valA_o(e_valA), .e_valB_o(e_valB),
        .e_valC_o(e_valC), .e_dstE_o(e_dstE), .e_dstM_o(e_dstM), .e_valid_o(e_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are then changed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] a, input logic [3:0] b);
        icode = ic; ifun = fn; rA = a; rB = b;
    endtask

    task automatic chk_nop(input string tag);
        chk({tag, "_icode"}, 64'(e_icode), 64'h1);
        chk({tag, "_ifun"},  64'(e_ifun),  64'h0);
        chk({tag, "_valA"},  e_valA,       64'h0);
        chk({tag, "_valB"},  e_valB,       64'h0);
        chk({tag, "_valC"},  e_valC,       64'h0);
        chk({tag, "_dstE"},  64'(e_dstE),  64'hF);
        chk({tag, "_dstM"},  64'(e_dstM),  64'hF);
        chk({tag, "_valid"}, 64'(e_valid), 64'h0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; bubble = 1'b0;
        fetch(4'h1, 4'h0, 4'hF, 4'hF);
        valC = '0; valP = '0;
        wE_dst = 4'hF; wE_val = '0; wM_dst = 4'hF; wM_val = '0;
        #12;
        chk_nop("reset");
        rst_n = 1'b1;

        // irmovq results written back into rax (0) and rbx (3)
        wE_dst = 4'h0; wE_val = 64'd3;
        step();
        wE_dst = 4'h3; wE_val = 64'd2;
        step();
        wE_dst = 4'hF;
        fetch(4'h6, 4'h0, 4'h0, 4'h3);          // addq %rax,%rbx
        step();
        chk("opq_icode", 64'(e_icode), 64'h6);
        chk("opq_ifun",  64'(e_ifun),  64'h0);
        chk("opq_valA",  e_valA, 64'd3);
        chk("opq_valB",  e_valB, 64'd2);
        chk("opq_dstE",  64'(e_dstE), 64'h3);
        chk("opq_dstM",  64'(e_dstM), 64'hF);
        chk("opq_valid", 64'(e_valid), 64'h1);

        // both writeback ports to rsp: M wins for bypass and for the write
        fetch(4'hA, 4'h0, 4'h4, 4'hF);          // pushq %rsp
        wM_dst = 4'h4; wM_val = 64'd9; wE_dst = 4'h4; wE_val = 64'd7;
        step();
        chk("push_valA", e_valA, 64'd9);
        chk("push_valB", e_valB, 64'd9);
        chk("push_dstE", 64'(e_dstE), 64'h4);
        wM_dst = 4'hF; wE_dst = 4'hF;
        fetch(4'h2, 4'h0, 4'h4, 4'h1);          // rrmovq %rsp,%rcx
        step();
        chk("rsp_stored", e_valA, 64'd9);
        chk("rrmov_dstE", 64'(e_dstE), 64'h1);

        // call: valA is valP, valB is rsp
        fetch(4'h8, 4'h0, 4'hF, 4'hF); valP = 64'h40;
        step();
        chk("call_valA", e_valA, 64'h40);
        chk("call_valB", e_valB, 64'd9);
        chk("call_dstE", 64'(e_dstE), 64'h4);
        chk("call_dstM", 64'(e_dstM), 64'hF);

        // E-only bypass on port A, array read on port B
        fetch(4'h6, 4'h1, 4'h2, 4'h0); wE_dst = 4'h2; wE_val = 64'h55;
        step();
        chk("ebyp_valA", e_valA, 64'h55);
        chk("ebyp_valB", e_valB, 64'd3);
        chk("ebyp_ifun", 64'(e_ifun), 64'h1);
        wE_dst = 4'hF;

        // popq %rsi: srcs/dstE = rsp, dstM = rA
        fetch(4'hB, 4'h0, 4'h6, 4'hF);
        step();
        chk("pop_valA", e_valA, 64'd9);
        chk("pop_dstE", 64'(e_dstE), 64'h4);
        chk("pop_dstM", 64'(e_dstM), 64'h6);

        // mrmovq 8(%rbx),%rdi
        fetch(4'h5, 4'h0, 4'h7, 4'h3); valC = 64'h8;
        step();
        chk("mrm_valB", e_valB, 64'd2);
        chk("mrm_dstE", 64'(e_dstE), 64'hF);
        chk("mrm_dstM", 64'(e_dstM), 64'h7);
        chk("mrm_valC", e_valC, 64'h8);

        // stall: load irmovq, freeze 3 cycles while writing r5 underneath
        fetch(4'h3, 4'h0, 4'hF, 4'h6); valC = 64'h77;
        step();
        stall = 1'b1;
        wE_dst = 4'h5; wE_val = 64'hAB;
        for (int i = 0; i < 3; i++) begin
            fetch(4'h6, 4'(i), 4'h0, 4'h3); valC = 64'(i + 100);
            step();
            chk("stall_icode", 64'(e_icode), 64'h3);
            chk("stall_valC",  e_valC, 64'h77);
            chk("stall_dstE",  64'(e_dstE), 64'h6);
            chk("stall_valid", 64'(e_valid), 64'h1);
            wE_dst = 4'hF;
        end
        stall = 1'b0;
        fetch(4'h2, 4'h0, 4'h5, 4'h7); valC = '0;
        step();
        chk("stall_wb", e_valA, 64'hAB);

        // bubble beats stall
        bubble = 1'b1; stall = 1'b1;
        step();
        chk_nop("bubble");
        bubble = 1'b0; stall = 1'b0;

        // unknown icode: passed through, no register specifiers
        fetch(4'hC, 4'h3, 4'h0, 4'h3);
        step();
        chk("unk_icode", 64'(e_icode), 64'hC);
        chk("unk_valA",  e_valA, 64'h0);
        chk("unk_dstE",  64'(e_dstE), 64'hF);
        chk("unk_valid", 64'(e_valid), 64'h1);

        // async reset between edges
        fetch(4'h6, 4'h0, 4'h0, 4'h3);
        step();
        chk("pre_rst_valid", 64'(e_valid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_nop("async_rst");
        #1 rst_n = 1'b1;
        fetch(4'h6, 4'h0, 4'h4, 4'h3);
        step();
        chk("rst_rsp_zero", e_valA, 64'h0);
        chk("rst_rbx_zero", e_valB, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
